// File: rtl/pcm_pkg.sv
// pcm_pkg: shared definitions for the multi-channel PCM playback engine.
//   SAMPLE_W  : width of a decoded PCM sample (signed)
//   OUT_W     : width of a volume-scaled channel output (signed)
//   state_t   : frame-fetch state machine encoding
//   vol_mult  : 4-bit log volume index -> linear multiplier (0..128)
package pcm_pkg;

  localparam int SAMPLE_W = 16;
  localparam int OUT_W    = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  // Log table scaled by two so that index 15 is exactly 2^7 (unity at 16-bit in, 23-bit out).
  function automatic logic [7:0] vol_mult(input logic [3:0] idx);
    logic [7:0] t;
    case (idx)
      4'd0:    t = 8'd0;
      4'd1:    t = 8'd1;
      4'd2:    t = 8'd2;
      4'd3:    t = 8'd3;
      4'd4:    t = 8'd4;
      4'd5:    t = 8'd5;
      4'd6:    t = 8'd6;
      4'd7:    t = 8'd8;
      4'd8:    t = 8'd11;
      4'd9:    t = 8'd14;
      4'd10:   t = 8'd18;
      4'd11:   t = 8'd23;
      4'd12:   t = 8'd30;
      4'd13:   t = 8'd38;
      4'd14:   t = 8'd49;
      4'd15:   t = 8'd64;
      default: t = 8'd0;
    endcase
    return {t[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous byte FIFO with occupancy count.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous clear (pointers and level to zero, same-cycle write dropped)
//   wr_en/wr_data : write strobe and byte, ignored while full
//   rd_en/rd_data : read strobe; rd_data is valid the cycle after rd_en
//   level/full/empty : occupancy status, derived from registered state
module pcm_fifo #(
  parameter int DEPTH = 4096,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = rd_data_q;

  // Next-state for pointers, level and read data; clear overrides any access.
  always_comb begin
    wr_ok     = wr_en && !full && !clr;
    rd_ok     = rd_en && !empty && !clr;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d  = rd_ptr_q;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/pcm_multi.sv
// pcm_multi: multi-channel PCM playback engine.
//   next_sample/sample_rate : base tick and phase increment of the rate divider
//   ch_mode/mode_16bit      : active channels minus one, sample format
//   volume                  : 4-bit log volume applied to every channel
//   underrun_hold           : on underrun keep last frame (1) or output zero (0)
//   fifo_*                  : CPU write side of the byte FIFO and its status
//   underrun/underrun_clr   : sticky underrun flag and its clear
//   audio_out/audio_valid   : NUM_CH x 23-bit signed outputs and update pulse
module pcm_multi
  import pcm_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int RATE_W     = 8,
  parameter int AE_LEVEL   = 1024,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    next_sample,
  input  logic [RATE_W-1:0]       sample_rate,
  input  logic [CH_W-1:0]         ch_mode,
  input  logic                    mode_16bit,
  input  logic [3:0]              volume,
  input  logic                    underrun_hold,
  input  logic                    fifo_reset,
  input  logic [7:0]              fifo_wrdata,
  input  logic                    fifo_write,
  output logic                    fifo_full,
  output logic                    fifo_almost_empty,
  output logic                    fifo_empty,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    underrun,
  input  logic                    underrun_clr,
  output logic [NUM_CH*OUT_W-1:0] audio_out,
  output logic                    audio_valid
);

  localparam int NBYTES = 2 * NUM_CH;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [RATE_W-1:0] RATE_FULL = {1'b1, {(RATE_W-1){1'b0}}};

  logic [RATE_W-1:0]          acc_q, acc_d, rate_eff;
  logic                       new_sample_q, new_sample_d;
  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]           cap_idx_q, cap_idx_d;
  logic [IDX_W-1:0]           b_last_q, b_last_d;
  logic [CH_W-1:0]            ch_cnt_q, ch_cnt_d;
  logic                       mode16_q, mode16_d;
  logic [7:0]                 stage_q [NBYTES];
  logic [7:0]                 stage_d [NBYTES];
  logic signed [SAMPLE_W-1:0] sample_q [NUM_CH];
  logic signed [SAMPLE_W-1:0] sample_d [NUM_CH];
  logic [NUM_CH*OUT_W-1:0]    audio_q, audio_d;
  logic                       valid_q, valid_d;
  logic                       underrun_q, underrun_d;
  logic                       underrun_set;
  logic                       rd_en;
  logic [7:0]                 fifo_rddata;
  logic [7:0]                 mult;
  logic signed [24:0]         prod;
  int                         ch_req;
  int                         frame_len;
  int                         src;

  pcm_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (fifo_reset),
    .wr_en   (fifo_write),
    .wr_data (fifo_wrdata),
    .rd_en   (rd_en),
    .rd_data (fifo_rddata),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_almost_empty = (int'(fifo_level) < AE_LEVEL);
  assign underrun          = underrun_q;
  assign audio_out         = audio_q;
  assign audio_valid       = valid_q;

  // Rate divider: a frame is due whenever the accumulator MSB toggles.
  always_comb begin
    if (sample_rate > RATE_FULL) begin
      rate_eff = RATE_FULL;
    end else begin
      rate_eff = sample_rate;
    end
    acc_d        = acc_q;
    new_sample_d = 1'b0;
    if (next_sample) begin
      acc_d        = acc_q + rate_eff;
      new_sample_d = acc_d[RATE_W-1] ^ acc_q[RATE_W-1];
    end else begin
      acc_d        = acc_q;
      new_sample_d = 1'b0;
    end
  end

  // Requested frame length in bytes from the live (clamped) configuration.
  always_comb begin
    if (int'(ch_mode) >= NUM_CH) begin
      ch_req = NUM_CH - 1;
    end else begin
      ch_req = int'(ch_mode);
    end
    if (mode_16bit) begin
      frame_len = (ch_req + 1) * 2;
    end else begin
      frame_len = ch_req + 1;
    end
  end

  // Frame fetch FSM, staging capture and output-register commit.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    cap_idx_d    = cap_idx_q;
    b_last_d     = b_last_q;
    ch_cnt_d     = ch_cnt_q;
    mode16_d     = mode16_q;
    stage_d      = stage_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    underrun_set = 1'b0;
    rd_en        = 1'b0;
    src          = 0;
    if (fifo_reset) begin
      // Abort: drop the partial frame, keep committed outputs.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (new_sample_q) begin
            if (int'(fifo_level) >= frame_len) begin
              state_d    = READ;
              byte_cnt_d = '0;
              cap_idx_d  = '0;
              b_last_d   = IDX_W'(frame_len - 1);
              ch_cnt_d   = CH_W'(ch_req);
              mode16_d   = mode_16bit;
            end else begin
              underrun_set = 1'b1;
              if (!underrun_hold) begin
                for (int k = 0; k < NUM_CH; k++) begin
                  sample_d[k] = '0;
                end
              end else begin
                sample_d = sample_q;
              end
            end
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          rd_en = 1'b1;
          // Read data lags rd_en by one cycle, so the first READ cycle has nothing to capture.
          if (byte_cnt_q != '0) begin
            stage_d[cap_idx_q] = fifo_rddata;
            cap_idx_d          = cap_idx_q + 1'b1;
          end else begin
            cap_idx_d = cap_idx_q;
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == b_last_q) begin
            state_d = LAST;
          end else begin
            state_d = READ;
          end
        end
        LAST: begin
          stage_d[cap_idx_q] = fifo_rddata;
          cap_idx_d          = cap_idx_q + 1'b1;
          state_d            = DONE;
        end
        DONE: begin
          // Channels beyond the active count replicate channel (k mod active).
          for (int k = 0; k < NUM_CH; k++) begin
            src = k % (int'(ch_cnt_q) + 1);
            if (mode16_q) begin
              sample_d[k] = {stage_q[2*src+1], stage_q[2*src]};
            end else begin
              sample_d[k] = {stage_q[src], 8'h00};
            end
          end
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky underrun flag; a new underrun wins over a same-cycle clear.
  always_comb begin
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Volume stage: scale the next output-register contents so audio_out lands with the commit.
  always_comb begin
    mult    = vol_mult(volume);
    prod    = '0;
    audio_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      prod = sample_d[k] * $signed({1'b0, mult});
      audio_d[k*OUT_W +: OUT_W] = prod[OUT_W-1:0];
    end
  end

  // All engine registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      new_sample_q <= 1'b0;
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      cap_idx_q    <= '0;
      b_last_q     <= '0;
      ch_cnt_q     <= '0;
      mode16_q     <= 1'b0;
      stage_q      <= '{default: 8'h00};
      sample_q     <= '{default: '0};
      audio_q      <= '0;
      valid_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      new_sample_q <= new_sample_d;
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      cap_idx_q    <= cap_idx_d;
      b_last_q     <= b_last_d;
      ch_cnt_q     <= ch_cnt_d;
      mode16_q     <= mode16_d;
      stage_q      <= stage_d;
      sample_q     <= sample_d;
      audio_q      <= audio_d;
      valid_q      <= valid_d;
      underrun_q   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pcm_multi.sv
// tb_pcm_multi: directed self-checking bench for pcm_multi (NUM_CH = 2, 4096-byte FIFO).
module tb_pcm_multi;
  import pcm_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int LVL_W  = 13;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    next_sample;
  logic [7:0]              sample_rate;
  logic [CH_W-1:0]         ch_mode;
  logic                    mode_16bit;
  logic [3:0]              volume;
  logic                    underrun_hold;
  logic                    fifo_reset;
  logic [7:0]              fifo_wrdata;
  logic                    fifo_write;
  logic                    fifo_full;
  logic                    fifo_almost_empty;
  logic                    fifo_empty;
  logic [LVL_W-1:0]        fifo_level;
  logic                    underrun;
  logic                    underrun_clr;
  logic [NUM_CH*23-1:0]    audio_out;
  logic                    audio_valid;

  int errors = 0;
  int checks = 0;
  int lat;
  int nv;
  int mtab [16] = '{0, 2, 4, 6, 8, 10, 12, 16, 22, 28, 36, 46, 60, 76, 98, 128};

  always #5 clk = ~clk;

  pcm_multi dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .next_sample       (next_sample),
    .sample_rate       (sample_rate),
    .ch_mode           (ch_mode),
    .mode_16bit        (mode_16bit),
    .volume            (volume),
    .underrun_hold     (underrun_hold),
    .fifo_reset        (fifo_reset),
    .fifo_wrdata       (fifo_wrdata),
    .fifo_write        (fifo_write),
    .fifo_full         (fifo_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_empty        (fifo_empty),
    .fifo_level        (fifo_level),
    .underrun          (underrun),
    .underrun_clr      (underrun_clr),
    .audio_out         (audio_out),
    .audio_valid       (audio_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] chv(input int k);
    logic [22:0] t;
    t = audio_out[23*k +: 23];
    return {{9{t[22]}}, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    fifo_wrdata = b;
    fifo_write  = 1'b1;
    tick();
    fifo_write  = 1'b0;
  endtask

  task automatic pulse();
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
  endtask

  // Returns cycles from new_sample to audio_valid, or -1 on timeout.
  task automatic run_frame(output int l);
    pulse();
    l = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (audio_valid === 1'b1) begin
        l = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; next_sample = 1'b0; sample_rate = 8'd128; ch_mode = 1'b1;
    mode_16bit = 1'b1; volume = 4'd15; underrun_hold = 1'b0; fifo_reset = 1'b0;
    fifo_wrdata = 8'h00; fifo_write = 1'b0; underrun_clr = 1'b0;
    repeat (3) tick();
    check("rst_empty", fifo_empty, 1);
    check("rst_ae", fifo_almost_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_audio", audio_out, 0);
    check("rst_valid", audio_valid, 0);
    check("rst_state", int'(dut.state_q), int'(IDLE));
    rst_n = 1'b1;
    tick();

    // 16-bit stereo frame
    write_byte(8'h34); write_byte(8'h12); write_byte(8'h78); write_byte(8'h56);
    check("s16_level4", fifo_level, 4);
    run_frame(lat);
    check("s16_latency", lat, 7);
    check("s16_ch0", chv(0), 32'sh00091A00);
    check("s16_ch1", chv(1), 32'sh002B3C00);
    check("s16_level0", fifo_level, 0);
    tick();
    check("s16_valid_pulse", audio_valid, 0);

    // 8-bit mono replicated to both channels
    ch_mode = 1'b0; mode_16bit = 1'b0; volume = 4'd7;
    write_byte(8'h80);
    run_frame(lat);
    check("m8_latency", lat, 4);
    check("m8_ch0", chv(0), -524288);
    check("m8_ch1", chv(1), -524288);
    check("m8_level0", fifo_level, 0);

    // Rate 32: 8 ticks give 2 frames
    sample_rate = 8'd32;
    write_byte(8'h01); write_byte(8'h02); write_byte(8'h03); write_byte(8'h04);
    nv = 0;
    for (int t = 0; t < 8; t++) begin
      pulse();
      for (int c = 0; c < 8; c++) begin
        tick();
        if (audio_valid === 1'b1) nv++;
      end
    end
    check("rate32_frames", nv, 2);
    check("rate32_level", fifo_level, 2);

    // Rate 200 clamps to full rate: one frame per tick
    sample_rate = 8'd200;
    write_byte(8'h10);
    nv = 0;
    for (int t = 0; t < 3; t++) begin
      pulse();
      for (int c = 0; c < 8; c++) begin
        tick();
        if (audio_valid === 1'b1) nv++;
      end
    end
    check("rate200_frames", nv, 3);
    check("rate200_level", fifo_level, 0);
    check("rate200_ch0", chv(0), 65536);
    check("rate200_ch1", chv(1), 65536);

    // Reference stereo frame A
    sample_rate = 8'd128; ch_mode = 1'b1; mode_16bit = 1'b1; volume = 4'd15;
    write_byte(8'h00); write_byte(8'h40); write_byte(8'h00); write_byte(8'h20);
    run_frame(lat);
    check("a_latency", lat, 7);
    check("a_ch0", chv(0), 2097152);
    check("a_ch1", chv(1), 1048576);

    // Underrun with hold
    underrun_hold = 1'b1;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    pulse();
    repeat (10) tick();
    check("uh_flag", underrun, 1);
    check("uh_level", fifo_level, 3);
    check("uh_ch0", chv(0), 2097152);
    check("uh_ch1", chv(1), 1048576);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check("uh_clr", underrun, 0);

    // Abort during READ; simultaneous write dropped
    write_byte(8'h44);
    check("ab_level4", fifo_level, 4);
    pulse();
    tick();
    check("ab_in_read", int'(dut.state_q), int'(READ));
    fifo_reset = 1'b1; fifo_write = 1'b1; fifo_wrdata = 8'h55;
    tick();
    fifo_reset = 1'b0; fifo_write = 1'b0;
    check("ab_state", int'(dut.state_q), int'(IDLE));
    check("ab_empty", fifo_empty, 1);
    check("ab_level", fifo_level, 0);
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (audio_valid === 1'b1) nv++;
    end
    check("ab_no_valid", nv, 0);
    check("ab_ch0", chv(0), 2097152);
    check("ab_underrun", underrun, 0);

    // Underrun with zero policy
    underrun_hold = 1'b0;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    pulse();
    repeat (10) tick();
    check("uz_flag", underrun, 1);
    check("uz_level", fifo_level, 3);
    check("uz_ch0", chv(0), 0);
    check("uz_ch1", chv(1), 0);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check("uz_clr", underrun, 0);
    fifo_reset = 1'b1; tick(); fifo_reset = 1'b0;

    // Fill to full, almost-empty threshold, overflow write ignored
    for (int i = 1; i <= 4096; i++) begin
      write_byte(i[7:0]);
      if (i == 1023) check("ae_1023", fifo_almost_empty, 1);
      if (i == 1024) check("ae_1024", fifo_almost_empty, 0);
    end
    check("full_flag", fifo_full, 1);
    check("full_level", fifo_level, 4096);
    write_byte(8'hAA);
    check("full_ovf_level", fifo_level, 4096);
    fifo_reset = 1'b1; tick(); fifo_reset = 1'b0;
    check("full_clr_empty", fifo_empty, 1);

    // Volume sweep on sample 0x4000
    write_byte(8'h00); write_byte(8'h40); write_byte(8'h00); write_byte(8'h40);
    run_frame(lat);
    check("vs_latency", lat, 7);
    for (int v = 0; v < 16; v++) begin
      volume = v[3:0];
      tick();
      check($sformatf("vol%0d_ch0", v), chv(0), mtab[v] * 16384);
      check($sformatf("vol%0d_valid", v), audio_valid, 0);
    end
    check("vol15_ch1", chv(1), 2097152);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_multi.md
Name: pcm_multi

Overview:
Parametrised PCM playback engine for the audio subsystem, next generation of the stereo PCM block. A CPU-written byte FIFO feeds frames of 1..NUM_CH channels in 8- or 16-bit format, paced by a phase-accumulator rate divider. Each channel is scaled by a 4-bit logarithmic volume. New over the previous generation:
- whole-frame fetch gating (no partial frames)
- selectable underrun policy (zero or hold)
- sticky underrun flag
- FIFO level output

Parameters:
NUM_CH, 2, channel outputs (1..8); CH_W = max(1, clog2(NUM_CH)).
FIFO_DEPTH, 4096, FIFO bytes (power of two); LVL_W = clog2(FIFO_DEPTH)+1.
RATE_W, 8, rate accumulator width; full rate = 2^(RATE_W-1).
AE_LEVEL, 1024, fifo_almost_empty asserted while level < AE_LEVEL.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
next_sample  in  1  base-rate tick, one cycle wide
sample_rate  in  RATE_W  increment per tick; values > 2^(RATE_W-1) clamp to 2^(RATE_W-1)
ch_mode  in  CH_W  active channel count minus 1; values >= NUM_CH clamp to NUM_CH-1
mode_16bit  in  1  1 = 16-bit little-endian samples; 0 = 8-bit
volume  in  4  log volume index
underrun_hold  in  1  1 = hold last frame on underrun; 0 = output zero
fifo_reset  in  1  synchronous FIFO clear
fifo_wrdata  in  8  write byte
fifo_write  in  1  write strobe; ignored when full
fifo_full  out  1  FIFO full
fifo_almost_empty  out  1  level < AE_LEVEL
fifo_empty  out  1  level == 0
fifo_level  out  LVL_W  bytes stored
underrun  out  1  sticky underrun flag
underrun_clr  in  1  clears underrun; a same-cycle set wins
audio_out  out  NUM_CH*23  signed channel outputs, channel k at bits [23k+22:23k]
audio_valid  out  1  one-cycle pulse when audio_out updates

Behaviour:
Reset (rst_n = 0 at a clk edge):
- all registers 0; FIFO cleared
- fifo_empty = 1, fifo_almost_empty = 1, fifo_full = 0, fifo_level = 0
- underrun = 0, audio_out = 0, audio_valid = 0, state = IDLE

Rate divider:
- on next_sample: acc <= acc + sample_rate (mod 2^RATE_W)
- new_sample is asserted in the following cycle iff acc MSB changed

Frame length:
- B = (ch_mode + 1) * (mode_16bit ? 2 : 1)
- ch_mode and mode_16bit are latched on IDLE->READ; changes mid-frame have no effect on that frame

FIFO read timing: rd_en in cycle N gives rddata valid in cycle N+1.

State machine:
- IDLE: on new_sample:
  - if fifo_level >= B: -> READ, reset byte counter.
  - else: set underrun; if !underrun_hold, clear all sample output registers to 0; stay IDLE.
- READ: assert rd_en each cycle for B cycles; capture rddata from the second READ cycle onward; after the B-th rd_en -> LAST.
- LAST: capture the final byte -> DONE.
- DONE: commit staging to output registers -> IDLE.
  - 8-bit byte b becomes sample {b, 8'h00}.
  - Byte order is ch0 lo, ch0 hi, ch1 lo, ... (8-bit: ch0, ch1, ...).
  - Channel k >= active count takes channel (k mod active).
- Frame latency: new_sample to commit = B + 2 cycles.
- new_sample outside IDLE is ignored (no underrun).

Abort: fifo_reset in any state forces IDLE next cycle. Staging is discarded and output registers are unchanged. Simultaneous fifo_write is dropped.

FIFO concurrency: write and read in the same cycle are both honoured; level is unchanged.

Volume:
- log table 0..15 -> 0,1,2,3,4,5,6,8,11,14,18,23,30,38,49,64; multiplier is 2*table (0..128)
- audio_out[k] <= signed sample_k * multiplier, registered, 23-bit result (no overflow possible)
- audio_out is 1 cycle after the output register commit; audio_valid pulses in that cycle
- a volume change alone updates audio_out one cycle later with no audio_valid pulse

Decomposition:
- pcm_pkg: SAMPLE_W = 16, OUT_W = 23, state enum (IDLE, READ, LAST, DONE), volume log-table function.
- Sub-module pcm_fifo: synchronous byte FIFO with level, one-cycle read latency, rst_n plus synchronous clear.
- pcm_multi contains the rate divider, FSM, staging/output registers and volume stage.

Test Plan:
- Reset, then NUM_CH = 2, 16-bit stereo: write 34 12 78 56, sample_rate = 128, pulse next_sample. Expect rd_en for 4 cycles; ch0 = 0x1234*128 = 0x091A00, ch1 = 0x5678*128 = 0x2B3C00 at volume 15; audio_valid 7 cycles after new_sample.
- 8-bit mono (ch_mode = 0), byte 0x80, volume 7: both channels = -32768*16 = -524288; fifo_level returns to 0.
- sample_rate = 32: 8 next_sample ticks produce exactly 2 frames. sample_rate = 200 behaves as 128 (one frame per tick).
- Underrun: 3 bytes queued in 16-bit stereo, new_sample. Expect no read, underrun = 1, level still 3. Outputs 0 with underrun_hold = 0, previous values with underrun_hold = 1. underrun_clr then clears the flag.
- fifo_reset during READ: FSM returns to IDLE, audio_out unchanged, fifo_empty = 1. Write at level FIFO_DEPTH is ignored and fifo_full = 1.
- Volume sweep 0..15 on a fixed sample 0x4000: outputs match 2*table*16384, e.g. volume 0 -> 0, volume 15 -> 2097152.
